cpu_host_ctrl: RTL and testbench
================================

CPU_HOST_CTRL -- requirements
Module: cpu_host_ctrl

Interface
REQ-001 Parameter CW, default 16: cycle counter width.
REQ-002 Parameter RST_CYC, default 2: number of cycles the core is held in reset per launch, minimum 1.
REQ-003 Parameter TIMEOUT_CYC, default 4095: maximum RUN cycles before abort; 1 <= TIMEOUT_CYC <= 2^CW-1.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  host launch request; sampled each cycle.
REQ-007 cpu_done  in  1  completion flag from the processor core's done output.
REQ-008 cpu_reset  out  1  drives the core's reset input.
REQ-009 cpu_req  out  1  drives the core's req input; one-cycle pulse.
REQ-010 busy  out  1  high in RESET_CORE, REQ and RUN.
REQ-011 finished  out  1  high in DONE.
REQ-012 timeout  out  1  high in TOUT.
REQ-013 cycle_count  out  CW  RUN cycles elapsed in the current or last run.
REQ-014 run_count  out  8  completed-run counter (see Configuration).

Function
REQ-015 The FSM SHALL have states IDLE, RESET_CORE, REQ, RUN, DONE and TOUT.
REQ-016 IDLE: cpu_reset=1, cpu_req=0. start=1 -> RESET_CORE, and cycle_count clears to 0.
REQ-017 RESET_CORE: cpu_reset=1 for exactly RST_CYC cycles via an internal counter, then -> REQ.
REQ-018 REQ: cpu_reset=0, cpu_req=1 for exactly one cycle, then -> RUN unconditionally.
REQ-019 RUN: cpu_reset=0, cpu_req=0, cpu_done sampled every cycle.
  - cpu_done=1 -> DONE, cycle_count holds.
  - Otherwise cycle_count increments; if the incremented value equals TIMEOUT_CYC -> TOUT.
REQ-020 cpu_done=1 and the timeout condition in the same RUN cycle: DONE wins, and cycle_count does not increment.
REQ-021 cpu_done SHALL be ignored in every state except RUN.
REQ-022 DONE and TOUT: cpu_reset=0, outputs hold. start=1 -> RESET_CORE with cycle_count cleared. This is the only way to exit without reset.
REQ-023 start SHALL be ignored while busy=1, with no queuing.
REQ-024 Launch latency: start sampled at edge N; cpu_reset low and cpu_req high in cycle N+RST_CYC+1; first RUN cycle N+RST_CYC+2.
REQ-025 Exactly one of busy, finished and timeout SHALL be high outside IDLE; all three are low in IDLE.

Reset
REQ-026 reset=1 at a clock edge SHALL force IDLE in any state, including mid-RUN, and override start.
REQ-027 Reset values: cpu_reset=1, cpu_req=0, busy=0, finished=0, timeout=0, cycle_count=0, run_count=0, internal reset counter=0.
REQ-028 A run aborted by reset SHALL NOT increment run_count.

Configuration
REQ-029 Macro HOST_RUN_COUNT_EN, when defined:
  - run_count increments by 1 on each RUN->DONE transition.
  - It saturates at 255.
  - It is not cleared by start, only by reset.
  - TOUT entries do not count.
REQ-030 HOST_RUN_COUNT_EN undefined: run_count is tied to 0, the port remains present, and no counter logic is synthesized.

Verification (RST_CYC=2, TIMEOUT_CYC=20, CW=16)
REQ-031 Reset, then start pulse at cycle 0 -> cpu_reset=1 in cycles 1-2; cpu_req=1 only in cycle 3; busy=1 in cycles 1 onward.
REQ-032 cpu_done asserted in the 6th RUN cycle -> finished=1 the next cycle, cycle_count=5, run_count=1 (macro on) or 0 (macro off).
REQ-033 cpu_done held low -> timeout=1 after 20 RUN cycles, cycle_count=20, run_count unchanged; then start -> cycle_count=0 and cpu_reset=1 next cycle.
REQ-034 cpu_done rises in the same cycle cycle_count=19 -> DONE (not TOUT), cycle_count=19.
REQ-035 Two checks on start and cpu_done:
  - start pulsed every cycle during RUN -> no relaunch, cpu_req pulses only once.
  - cpu_done=1 throughout RESET_CORE and REQ -> ignored until RUN.
REQ-036 reset asserted in the 10th RUN cycle -> next cycle is IDLE with cpu_reset=1, cycle_count=0, run_count=0.

Source files
------------

// File: rtl/cpu_host_ctrl.sv
// Host-side launcher for a processor core: holds the core in reset, pulses req, then times the run.
// Optional completed-run counter enabled by defining HOST_RUN_COUNT_EN.
module cpu_host_ctrl #(
  parameter int CW          = 16,
  parameter int RST_CYC     = 2,
  parameter int TIMEOUT_CYC = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          cpu_done,
  output logic          cpu_reset,
  output logic          cpu_req,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycle_count,
  output logic [7:0]    run_count
);

  typedef enum logic [2:0] {
    IDLE,
    RESET_CORE,
    REQ,
    RUN,
    DONE,
    TOUT
  } state_t;

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  state_t        state;
  state_t        nextState;
  logic [RW-1:0] rstCnt;
  logic [CW-1:0] cntInc;
  logic          rstLast;
  logic          launch;

  assign cntInc  = cycle_count + CW'(1);
  assign rstLast = (rstCnt == RW'(RST_CYC - 1));

  // NOTE: every output gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    nextState = state;
    launch    = 1'b0;
    cpu_reset = 1'b0;
    cpu_req   = 1'b0;
    busy      = 1'b0;
    finished  = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        cpu_reset = 1'b1;
        if (start) begin
          nextState = RESET_CORE;
          launch    = 1'b1;
        end
      end
      RESET_CORE: begin
        cpu_reset = 1'b1;
        busy      = 1'b1;
        if (rstLast) nextState = REQ;
      end
      REQ: begin
        cpu_req   = 1'b1;
        busy      = 1'b1;
        nextState = RUN;
      end
      RUN: begin
        busy = 1'b1;
        // Completion beats timeout when both land in the same cycle.
        if (cpu_done)                          nextState = DONE;
        else if (cntInc == CW'(TIMEOUT_CYC))   nextState = TOUT;
      end
      DONE: begin
        finished = 1'b1;
        if (start) begin
          nextState = RESET_CORE;
          launch    = 1'b1;
        end
      end
      TOUT: begin
        timeout = 1'b1;
        if (start) begin
          nextState = RESET_CORE;
          launch    = 1'b1;
        end
      end
      default: begin
        cpu_reset = 1'b1;
        nextState = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rstCnt      <= '0;
      cycle_count <= '0;
    end else begin
      state <= nextState;
      if (state == RESET_CORE && !rstLast) rstCnt <= rstCnt + RW'(1);
      else                                 rstCnt <= '0;
      if (launch)                          cycle_count <= '0;
      else if (state == RUN && !cpu_done)  cycle_count <= cntInc;
    end
  end

`ifdef HOST_RUN_COUNT_EN
  logic [7:0] runCnt;

  // Counts successful completions only; saturates and survives relaunches.
  always_ff @(posedge clk) begin
    if (reset)                                         runCnt <= '0;
    else if (state == RUN && cpu_done && runCnt != 8'hFF) runCnt <= runCnt + 8'd1;
  end

  assign run_count = runCnt;
`else
  assign run_count = 8'd0;
`endif

endmodule

// File: tb/tb_cpu_host_ctrl.sv
// Scoreboard bench for cpu_host_ctrl: stimulus queues expected req/done/timeout events,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_cpu_host_ctrl;

  localparam int CW = 16;

  typedef enum int {EV_REQ, EV_DONE, EV_TOUT} evKind_t;
  typedef struct {
    evKind_t kind;
    int      cnt;
    int      runc;
  } ev_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          cpu_done;
  logic          cpu_reset;
  logic          cpu_req;
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [CW-1:0] cycle_count;
  logic [7:0]    run_count;

  int  checks = 0;
  int  errors = 0;
  int  runExp = 0;
  ev_t sbQ[$];
  logic prevFin = 1'b0;
  logic prevTout = 1'b0;

  cpu_host_ctrl #(.CW(CW), .RST_CYC(2), .TIMEOUT_CYC(20)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .cpu_done   (cpu_done),
    .cpu_reset  (cpu_reset),
    .cpu_req    (cpu_req),
    .busy       (busy),
    .finished   (finished),
    .timeout    (timeout),
    .cycle_count(cycle_count),
    .run_count  (run_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input evKind_t k, input int cnt, input int runc);
    ev_t e;
    e.kind = k;
    e.cnt  = cnt;
    e.runc = runc;
    sbQ.push_back(e);
  endtask

  task automatic countDone();
`ifdef HOST_RUN_COUNT_EN
    if (runExp < 255) runExp++;
`endif
  endtask

  task automatic popCheck(input evKind_t k);
    ev_t e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got %s expected none (t=%0t)", k.name(), $time);
    end else begin
      e = sbQ.pop_front();
      check("ev_kind", k, e.kind);
      check("ev_cycle_count", cycle_count, e.cnt);
      if (k == EV_REQ) check("ev_req_cpu_reset", cpu_reset, 0);
      else             check("ev_run_count", run_count, e.runc);
    end
  endtask

  // Monitor: compares events against the scoreboard and checks status exclusivity.
  always @(negedge clk) begin
    if (!reset) begin
      check("status_onehot", (int'(busy) + int'(finished) + int'(timeout)) > 1, 0);
      if (cpu_req)               popCheck(EV_REQ);
      if (finished && !prevFin)  popCheck(EV_DONE);
      if (timeout && !prevTout)  popCheck(EV_TOUT);
    end
    prevFin  <= finished;
    prevTout <= timeout;
  end

  // Launch from IDLE/DONE/TOUT and advance to the first RUN cycle.
  task automatic launch();
    pushExp(EV_REQ, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    check("run1_busy", busy, 1);
    check("run1_cycle_count", cycle_count, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100us");
    $fatal(1, "watchdog");
  end

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    cpu_done = 1'b0;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    tick();
    check("idle_cpu_reset", cpu_reset, 1);
    check("idle_cpu_req", cpu_req, 0);
    check("idle_status", {busy, finished, timeout}, 0);
    check("idle_cycle_count", cycle_count, 0);
    check("idle_run_count", run_count, 0);

    // Launch timing: start at cycle 0, reset held cycles 1-2, req in cycle 3.
    pushExp(EV_REQ, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("c1_cpu_reset", cpu_reset, 1);
    check("c1_req_busy", {cpu_req, busy}, 2'b01);
    tick();
    check("c2_cpu_reset", cpu_reset, 1);
    check("c2_req_busy", {cpu_req, busy}, 2'b01);
    tick();
    check("c3_cpu_reset", cpu_reset, 0);
    check("c3_req_busy", {cpu_req, busy}, 2'b11);
    tick();
    check("run1_req", cpu_req, 0);
    check("run1_cycle_count", cycle_count, 0);
    repeat (5) tick();
    check("run6_cycle_count", cycle_count, 5);
    cpu_done = 1'b1;
    countDone();
    pushExp(EV_DONE, 5, runExp);
    tick();
    cpu_done = 1'b0;
    check("done_finished", finished, 1);
    check("done_cycle_count", cycle_count, 5);

    // Timeout after 20 RUN cycles, relaunched from DONE.
    launch();
    pushExp(EV_TOUT, 20, runExp);
    repeat (19) tick();
    check("run20_timeout", timeout, 0);
    check("run20_cycle_count", cycle_count, 19);
    tick();
    check("tout_timeout", timeout, 1);
    check("tout_cycle_count", cycle_count, 20);
    check("tout_run_count", run_count, runExp);
    cpu_done = 1'b1;
    repeat (3) tick();
    check("tout_hold", {timeout, finished, cycle_count}, {2'b10, 16'd20});

    // Relaunch from TOUT with cpu_done held high through RESET_CORE and REQ.
    pushExp(EV_REQ, 0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("relaunch_cycle_count", cycle_count, 0);
    check("relaunch_cpu_reset", cpu_reset, 1);
    tick();
    tick();
    check("req_ignores_done", {cpu_req, finished}, 2'b10);
    cpu_done = 1'b0;
    tick();
    check("run1_after_done_high", {busy, finished}, 2'b10);
    repeat (19) tick();
    check("edge_cycle_count", cycle_count, 19);
    cpu_done = 1'b1;
    countDone();
    pushExp(EV_DONE, 19, runExp);
    tick();
    cpu_done = 1'b0;
    check("edge_done_not_tout", {finished, timeout}, 2'b10);
    check("edge_cycle_count_hold", cycle_count, 19);

    // start pulsed every RUN cycle: no relaunch, single req pulse.
    launch();
    start = 1'b1;
    repeat (8) tick();
    start = 1'b0;
    check("run_start_ignored", cycle_count, 8);
    cpu_done = 1'b1;
    countDone();
    pushExp(EV_DONE, 8, runExp);
    tick();
    cpu_done = 1'b0;
    check("run_start_done", finished, 1);

    // Reset in the 10th RUN cycle, with start also asserted.
    launch();
    repeat (9) tick();
    check("run10_cycle_count", cycle_count, 9);
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    runExp = 0;
    check("abort_cpu_reset", cpu_reset, 1);
    check("abort_status", {busy, finished, timeout, cpu_req}, 0);
    check("abort_cycle_count", cycle_count, 0);
    check("abort_run_count", run_count, runExp);
    repeat (3) tick();
    check("abort_idle_hold", {cpu_reset, busy}, 2'b10);
    check("sb_drained", sbQ.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
